// File: rtl/wb4_pkg.sv
// Shared Wishbone B4 constants and the slave FSM state type, used by the
// slave memory and reusable by a matching master.
package wb4_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_BURST
  } wb4_state_e;

  // Byte-lane merge: lanes with sel=1 take the new data, the rest keep old.
  function automatic logic [31:0] wb4_merge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0]  sel);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      r[8*k +: 8] = sel[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    return r;
  endfunction

endpackage

// File: rtl/wb4_slave_mem_if.sv
// Wishbone B4 bus bundle between the bench master and the slave memory.
// The err signal exists only when WB4_SLAVE_ERR_EN is defined.
interface wb4_slave_mem_if;
  logic [31:0] adr;
  logic [1:0]  bte;
  logic [2:0]  cti;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic [15:0] wr_count;
  logic        protocol_err;
`ifdef WB4_SLAVE_ERR_EN
  logic        err;

  modport master (output adr, bte, cti, cyc, stb, we, sel, dat_i,
                  input  ack, dat_o, wr_count, protocol_err, err);
  modport slave  (input  adr, bte, cti, cyc, stb, we, sel, dat_i,
                  output ack, dat_o, wr_count, protocol_err, err);
`else
  modport master (output adr, bte, cti, cyc, stb, we, sel, dat_i,
                  input  ack, dat_o, wr_count, protocol_err);
  modport slave  (input  adr, bte, cti, cyc, stb, we, sel, dat_i,
                  output ack, dat_o, wr_count, protocol_err);
`endif
endinterface

// File: rtl/wb4_burst_addr.sv
// Next expected word index of a Wishbone incrementing burst for a given bte.
// Linear wraps at the full index width; wrapN holds the upper bits.
module wb4_burst_addr
  import wb4_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic [AW-1:0] i_idx,
  input  logic [1:0]    i_bte,
  output logic [AW-1:0] o_nxt
);

  logic [AW-1:0] w_mask;
  logic [AW-1:0] w_inc;

  always_comb begin
    w_inc = i_idx + AW'(1);
    unique case (i_bte)
      BTE_WRAP4:  w_mask = AW'(3);
      BTE_WRAP8:  w_mask = AW'(7);
      BTE_WRAP16: w_mask = AW'(15);
      default:    w_mask = '1;
    endcase
    o_nxt = (i_idx & ~w_mask) | (w_inc & w_mask);
  end

endmodule

// File: rtl/wb4_slave_mem.sv
// Wishbone B4 slave memory: byte-enabled words, wait states, bursts with an
// address checker. Define WB4_SLAVE_ERR_EN to answer out-of-range beats with err.
module wb4_slave_mem
  import wb4_pkg::*;
#(
  parameter logic [31:0] BASE_ADR    = 32'h0000_1000,
  parameter int          AW          = 4,
  parameter int          WAIT_STATES = 0
) (
  input logic            clk,
  input logic            reset_n,
  wb4_slave_mem_if.slave bus
);

  localparam int DEPTH = 1 << AW;

  wb4_state_e    r_state;
  logic [3:0]    r_wcnt;
  logic          r_ack;
  logic [AW-1:0] r_exp;
  logic          r_perr;
  logic [15:0]   r_wr_count;
  logic [31:0]   r_mem [DEPTH];

  logic [AW-1:0] w_idx;
  logic [AW-1:0] w_nxt;
  logic          w_hit;
  logic          w_beat;
  logic          w_wr;
  logic          w_term;
  logic          w_unused;

  assign w_idx    = bus.adr[AW+1:2];
  assign w_hit    = (bus.adr[31:AW+2] == BASE_ADR[31:AW+2]);
  assign w_unused = &{1'b0, bus.adr[1:0]};

  // r_ack arms the response; the live strobe qualifies each beat so a
  // master pausing stb inside a burst sees no ack.
  assign w_beat = r_ack & bus.cyc & bus.stb;
  assign w_wr   = w_beat & w_hit & bus.we;

`ifdef WB4_SLAVE_ERR_EN
  assign bus.ack = w_beat & w_hit;
  assign bus.err = w_beat & ~w_hit;
  assign w_term  = w_beat & ~w_hit;
`else
  assign bus.ack = w_beat;
  assign w_term  = 1'b0;
`endif

  assign bus.dat_o        = (w_beat & w_hit & ~bus.we) ? r_mem[w_idx] : '0;
  assign bus.wr_count     = r_wr_count;
  assign bus.protocol_err = r_perr;

  wb4_burst_addr #(.AW(AW)) u_burst_addr (
    .i_idx (w_idx),
    .i_bte (bus.bte),
    .o_nxt (w_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_wcnt  <= '0;
      r_ack   <= 1'b0;
      r_exp   <= '0;
      r_perr  <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.cyc && bus.stb) begin
            if (WAIT_STATES > 0) begin
              r_state <= ST_WAIT;
              r_wcnt  <= 4'(WAIT_STATES - 1);
            end else begin
              r_state <= ST_ACK;
              r_ack   <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (!bus.cyc) begin
            r_state <= ST_IDLE;
          end else if (r_wcnt == 4'd0) begin
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        ST_ACK: begin
          if (w_beat && !w_term && bus.cti == CTI_INCR) begin
            r_state <= ST_BURST;
            r_exp   <= w_nxt;
          end else begin
            // Classic and end-of-burst both drop ack, leaving one dead cycle.
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
          end
        end
        ST_BURST: begin
          if (!bus.cyc) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
          end else if (bus.stb) begin
            if (w_idx != r_exp)
              r_perr <= 1'b1;
            if (w_term || bus.cti != CTI_INCR) begin
              r_state <= ST_IDLE;
              r_ack   <= 1'b0;
            end else begin
              r_exp <= w_nxt;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

  // Memory contents are part of the reset state, so an interrupted burst
  // leaves nothing behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_count <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (w_wr) begin
      if (r_wr_count != 16'hFFFF)
        r_wr_count <= r_wr_count + 16'd1;
      r_mem[w_idx] <= wb4_merge(r_mem[w_idx], bus.dat_i, bus.sel);
    end
  end

endmodule

// File: tb/tb_wb4_slave_mem.sv
// Scoreboard bench for wb4_slave_mem: a driver pushes expected responses,
// a negedge monitor pops and compares on every ack (or err).
module tb_wb4_slave_mem;
  import wb4_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  wb4_slave_mem_if bus ();
  wb4_slave_mem_if bus3 ();

  wb4_slave_mem #(.BASE_ADR(32'h0000_1000), .AW(4), .WAIT_STATES(0)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
  wb4_slave_mem #(.BASE_ADR(32'h0000_1000), .AW(4), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(bus3));

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        is_err;
    logic        is_rd;
    logic [31:0] data;
    string       name;
  } exp_t;
  exp_t sb[$];

  logic [31:0] model [16];
  int          model_wc;
  logic        model_perr;

  logic bus_resp;
`ifdef WB4_SLAVE_ERR_EN
  assign bus_resp = bus.ack | bus.err;
`else
  assign bus_resp = bus.ack;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic logic in_range(input logic [31:0] a);
    return a[31:6] == 26'h40;
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  function automatic int next_idx(input int idx, input logic [1:0] b);
    int n;
    int base;
    n = (b == BTE_WRAP4) ? 4 : (b == BTE_WRAP8) ? 8 : 16;
    base = idx - (idx % n);
    return (b == BTE_LINEAR) ? (idx + 1) % 16 : base + ((idx % n) + 1) % n;
  endfunction

  // Reference model: one beat, expected response queued for the monitor.
  task automatic model_beat(input logic [31:0] a, input logic w, input logic [3:0] s,
                            input logic [31:0] d, input string nm);
    exp_t e;
    int   i;
    i = int'(a[5:2]);
    e.name   = nm;
    e.is_rd  = !w;
    e.is_err = 1'b0;
`ifdef WB4_SLAVE_ERR_EN
    e.is_err = !in_range(a);
`endif
    e.data = in_range(a) ? model[i] : 32'h0;
    if (w && in_range(a)) begin
      model[i] = lanes(model[i], d, s);
      if (model_wc < 65535) model_wc++;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n && bus_resp) begin
      if (sb.size() == 0) begin
        check("unexpected_resp", 32'(bus_resp), 32'h0);
      end else begin
        e = sb.pop_front();
`ifdef WB4_SLAVE_ERR_EN
        check({e.name, "_err"}, 32'(bus.err), 32'(e.is_err));
`endif
        check({e.name, "_dat"}, bus.dat_o, e.is_rd ? e.data : 32'h0);
      end
    end
  end

  task automatic wait_resp(output int lat);
    lat = 0;
    @(negedge clk);
    while (!bus_resp && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic bus_idle();
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.cti = CTI_CLASSIC;
    @(posedge clk); #1;
  endtask

  // Leaves cyc/stb high so consecutive calls are back-to-back classic cycles.
  task automatic classic(input logic [31:0] a, input logic w, input logic [3:0] s,
                         input logic [31:0] d, input string nm);
    int lat;
    bus.adr = a; bus.we = w; bus.sel = s; bus.dat_i = d;
    bus.cti = CTI_CLASSIC; bus.bte = BTE_LINEAR; bus.cyc = 1'b1; bus.stb = 1'b1;
    model_beat(a, w, s, d, nm);
    wait_resp(lat);
    check({nm, "_lat"}, 32'(lat), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic burst(input int idx0, input logic [1:0] b, input int len, input logic w,
                       input int bad_beat, input logic gaps, input string nm);
    int idx;
    int lat;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    idx = idx0;
    for (int i = 0; i < len; i++) begin
      if (gaps && i > 0 && ($urandom % 3 == 0)) begin
        bus.stb = 1'b0;
        @(negedge clk);
        check({nm, "_gap_ack"}, 32'(bus.ack), 32'h0);
        @(posedge clk); #1;
      end
      a = (i == bad_beat) ? 32'h1000 + 32'(((idx + 4) % 16) * 4) : 32'h1000 + 32'(idx * 4);
      if (i == bad_beat) model_perr = 1'b1;
      d = $urandom;
      s = 4'($urandom);
      bus.adr = a; bus.we = w; bus.sel = s; bus.dat_i = d; bus.bte = b;
      bus.cti = (i == len - 1) ? CTI_EOB : CTI_INCR;
      bus.cyc = 1'b1; bus.stb = 1'b1;
      model_beat(a, w, s, d, nm);
      wait_resp(lat);
      check({nm, "_lat"}, 32'(lat), (i == 0) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      idx = next_idx(idx, b);
    end
    bus_idle();
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic pre_ok;
    bus.adr = '0; bus.bte = '0; bus.cti = '0; bus.cyc = 0; bus.stb = 0;
    bus.we = 0; bus.sel = '0; bus.dat_i = '0;
    bus3.adr = '0; bus3.bte = '0; bus3.cti = '0; bus3.cyc = 0; bus3.stb = 0;
    bus3.we = 0; bus3.sel = '0; bus3.dat_i = '0;
    for (int i = 0; i < 16; i++) model[i] = '0;
    model_wc = 0;
    model_perr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(bus.ack), 32'h0);
    check("rst_dat", bus.dat_o, 32'h0);
    check("rst_wrcnt", 32'(bus.wr_count), 32'h0);
    check("rst_perr", 32'(bus.protocol_err), 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    classic(32'h1000, 1, 4'hF, 32'h1234_5678, "wr0");
    classic(32'h1004, 1, 4'hF, 32'h2000_0002, "wr1");
    classic(32'h1008, 1, 4'hF, 32'h3000_0003, "wr2");
    classic(32'h100c, 1, 4'hF, 32'h4000_0004, "wr3");
    bus_idle();
    check("wrcnt_4", 32'(bus.wr_count), 32'd4);
    classic(32'h1000, 0, 4'hF, 32'h0, "rd0");
    classic(32'h1004, 0, 4'hF, 32'h0, "rd1");
    classic(32'h1008, 0, 4'hF, 32'h0, "rd2");
    classic(32'h100c, 0, 4'hF, 32'h0, "rd3");
    bus_idle();

    classic(32'h1000, 1, 4'b0101, 32'hAABB_CCDD, "wr_lane");
    bus_idle();
    classic(32'h1000, 0, 4'hF, 32'h0, "rd_lane");
    bus_idle();

    classic(32'h1008, 1, 4'b0000, 32'hFFFF_FFFF, "wr_sel0");
    bus_idle();
    check("wrcnt_sel0", 32'(bus.wr_count), 32'(model_wc));
    classic(32'h1008, 0, 4'hF, 32'h0, "rd_sel0");
    bus_idle();

    burst(2, BTE_WRAP4, 4, 1'b1, -1, 1'b0, "wrap4");
    check("perr_clean", 32'(bus.protocol_err), 32'h0);
    burst(2, BTE_WRAP4, 4, 1'b0, 2, 1'b0, "wrap4_bad");
    check("perr_set", 32'(bus.protocol_err), 32'h1);
    burst(0, BTE_LINEAR, 3, 1'b1, -1, 1'b0, "lin_after");
    check("perr_sticky", 32'(bus.protocol_err), 32'h1);

    classic(32'h2000, 1, 4'hF, 32'hDEAD_BEEF, "oor_wr");
    bus_idle();
    check("wrcnt_oor", 32'(bus.wr_count), 32'(model_wc));
    classic(32'h2000, 0, 4'hF, 32'h0, "oor_rd");
    bus_idle();

    repeat (30) begin
      if ($urandom % 3 == 0) begin
        classic(($urandom % 8 == 0) ? 32'h3000 : 32'h1000 + 32'($urandom_range(0, 15) * 4),
                1'($urandom), 4'($urandom), $urandom, "rnd_cl");
        bus_idle();
      end else begin
        burst($urandom_range(0, 15), 2'($urandom), $urandom_range(2, 6), 1'($urandom),
              -1, 1'b1, "rnd_bu");
      end
    end
    check("rnd_wrcnt", 32'(bus.wr_count), 32'(model_wc));
    check("rnd_perr", 32'(bus.protocol_err), 32'(model_perr));
    for (int i = 0; i < 16; i++) classic(32'h1000 + 32'(i * 4), 0, 4'hF, 32'h0, "dump");
    bus_idle();

    // Three wait states on the second instance.
    bus3.adr = 32'h1004; bus3.we = 1; bus3.sel = 4'hF; bus3.dat_i = 32'h2000_0002;
    bus3.cti = CTI_CLASSIC; bus3.cyc = 1; bus3.stb = 1;
    lat = 0;
    @(negedge clk);
    while (!bus3.ack && lat < 50) begin @(negedge clk); lat++; end
    check("ws_wr_lat", 32'(lat), 32'd4);
    @(posedge clk); #1;
    bus3.cyc = 0; bus3.stb = 0;
    @(posedge clk); #1;
    bus3.we = 0; bus3.cyc = 1; bus3.stb = 1;
    lat = 0;
    pre_ok = 1'b1;
    @(negedge clk);
    while (!bus3.ack && lat < 50) begin
      if (bus3.dat_o != 32'h0) pre_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    check("ws_rd_lat", 32'(lat), 32'd4);
    check("ws_rd_dat", bus3.dat_o, 32'h2000_0002);
    check("ws_pre_dat", 32'(pre_ok), 32'h1);
    @(posedge clk); #1;
    bus3.cyc = 0; bus3.stb = 0;
    @(negedge clk);
    check("ws_post_ack", 32'(bus3.ack), 32'h0);
    check("ws_post_dat", bus3.dat_o, 32'h0);
    @(posedge clk); #1;

    // Reset asserted in the middle of beat 2 of a linear write burst.
    bus.adr = 32'h1000; bus.we = 1; bus.sel = 4'hF; bus.dat_i = 32'hCAFE_0001;
    bus.bte = BTE_LINEAR; bus.cti = CTI_INCR; bus.cyc = 1; bus.stb = 1;
    model_beat(32'h1000, 1, 4'hF, 32'hCAFE_0001, "rst_b0");
    wait_resp(lat);
    check("rst_b0_lat", 32'(lat), 32'd1);
    @(posedge clk); #1;
    bus.adr = 32'h1004; bus.dat_i = 32'hCAFE_0002;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_ack", 32'(bus.ack), 32'h0);
    sb.delete();
    for (int i = 0; i < 16; i++) model[i] = '0;
    model_wc = 0;
    model_perr = 1'b0;
    check("rst_mid_wrcnt", 32'(bus.wr_count), 32'h0);
    check("rst_mid_perr", 32'(bus.protocol_err), 32'h0);
    bus.cyc = 0; bus.stb = 0; bus.we = 0; bus.cti = CTI_CLASSIC;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) classic(32'h1000 + 32'(i * 4), 0, 4'hF, 32'h0, "rst_rd");
    bus_idle();
    check("rst_sb_empty", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
